// File: rtl/ls_mem_scheduler_if.sv
// Bundle between the load/store reservation entries, data memory and CDB.
// master: the scheduler side; slave: the surrounding environment.
interface ls_mem_scheduler_if #(
  parameter int XLEN       = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4
);
  logic                        issue_valid;
  logic [TAG_WIDTH-1:0]        issue_tag;
  logic [1:0]                  ld_ready;
  logic [1:0]                  st_ready;
  logic [2*XLEN-1:0]           ld_addr;
  logic [2*XLEN-1:0]           st_addr;
  logic [2*XLEN-1:0]           st_data;
  logic                        mem_req;
  logic                        mem_we;
  logic [XLEN-1:0]             mem_addr;
  logic [XLEN-1:0]             mem_wdata;
  logic                        mem_ack;
  logic [XLEN-1:0]             mem_rdata;
  logic                        cdb_req;
  logic [TAG_WIDTH-1:0]        cdb_tag;
  logic [XLEN-1:0]             cdb_data;
  logic                        cdb_grant;
  logic [1:0]                  ld_free;
  logic [1:0]                  st_free;
  logic                        q_full;
  logic [$clog2(FIFO_DEPTH):0] q_count;
  logic                        overflow_err;

  modport master (
    input  issue_valid, issue_tag, ld_ready, st_ready,
    input  ld_addr, st_addr, st_data,
    input  mem_ack, mem_rdata, cdb_grant,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output cdb_req, cdb_tag, cdb_data,
    output ld_free, st_free, q_full, q_count, overflow_err
  );

  modport slave (
    output issue_valid, issue_tag, ld_ready, st_ready,
    output ld_addr, st_addr, st_data,
    output mem_ack, mem_rdata, cdb_grant,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  cdb_req, cdb_tag, cdb_data,
    input  ld_free, st_free, q_full, q_count, overflow_err
  );
endinterface

// File: rtl/ls_mem_scheduler.sv
// In-order memory access sequencer for two load and two store entries.
// One access in flight; loads finish through a CDB grant.
module ls_mem_scheduler #(
  parameter int                   FIFO_DEPTH = 4,
  parameter int                   TAG_WIDTH  = 4,
  parameter int                   XLEN       = 32,
  parameter logic [TAG_WIDTH-1:0] LOAD1_TAG  = 4'd5,
  parameter logic [TAG_WIDTH-1:0] LOAD2_TAG  = 4'd6,
  parameter logic [TAG_WIDTH-1:0] STORE1_TAG = 4'd7,
  parameter logic [TAG_WIDTH-1:0] STORE2_TAG = 4'd8
) (
  input logic                clk,
  input logic                reset,
  ls_mem_scheduler_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_WAIT,
    S_CDB_WAIT
  } state_t;

  state_t r_state, w_state_nxt;

  logic [TAG_WIDTH-1:0] r_q [FIFO_DEPTH];
  logic [PW-1:0]        r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]        r_count, w_count_nxt;
  logic                 r_full, r_ovf;

  logic                 r_mem_req, w_mem_req_n;
  logic                 r_mem_we, w_mem_we_n;
  logic [XLEN-1:0]      r_mem_addr, w_mem_addr_n;
  logic [XLEN-1:0]      r_mem_wdata, w_mem_wdata_n;
  logic                 r_cdb_req, w_cdb_req_n;
  logic [TAG_WIDTH-1:0] r_cdb_tag, w_cdb_tag_n;
  logic [XLEN-1:0]      r_cdb_data, w_cdb_data_n;
  logic [1:0]           r_ld_free, w_ld_free_n;
  logic [1:0]           r_st_free, w_st_free_n;

  logic [TAG_WIDTH-1:0] w_head;
  logic                 w_empty;
  logic                 w_hd_ld, w_hd_idx, w_hd_rdy;
  logic [XLEN-1:0]      w_sel_addr, w_sel_data;
  logic                 w_tag_ok, w_push, w_pop;

  assign w_head  = r_q[r_rd_ptr];
  assign w_empty = (r_count == '0);

  assign w_tag_ok = (bus.issue_tag == LOAD1_TAG)  ||
                    (bus.issue_tag == LOAD2_TAG)  ||
                    (bus.issue_tag == STORE1_TAG) ||
                    (bus.issue_tag == STORE2_TAG);

  // a full queue still accepts a push when the head retires this cycle
  assign w_push = bus.issue_valid && w_tag_ok && (!r_full || w_pop);

  always_comb begin
    w_hd_ld  = 1'b0;
    w_hd_idx = 1'b0;
    w_hd_rdy = 1'b0;
    unique case (1'b1)
      (w_head == LOAD1_TAG): begin
        w_hd_ld  = 1'b1;
        w_hd_rdy = bus.ld_ready[0];
      end
      (w_head == LOAD2_TAG): begin
        w_hd_ld  = 1'b1;
        w_hd_idx = 1'b1;
        w_hd_rdy = bus.ld_ready[1];
      end
      (w_head == STORE1_TAG): begin
        w_hd_rdy = bus.st_ready[0];
      end
      (w_head == STORE2_TAG): begin
        w_hd_idx = 1'b1;
        w_hd_rdy = bus.st_ready[1];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    if (w_hd_ld) begin
      w_sel_addr = w_hd_idx ? bus.ld_addr[2*XLEN-1:XLEN]
                            : bus.ld_addr[XLEN-1:0];
    end else begin
      w_sel_addr = w_hd_idx ? bus.st_addr[2*XLEN-1:XLEN]
                            : bus.st_addr[XLEN-1:0];
      w_sel_data = w_hd_idx ? bus.st_data[2*XLEN-1:XLEN]
                            : bus.st_data[XLEN-1:0];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mem_req_n   = r_mem_req;
    w_mem_we_n    = r_mem_we;
    w_mem_addr_n  = r_mem_addr;
    w_mem_wdata_n = r_mem_wdata;
    w_cdb_req_n   = r_cdb_req;
    w_cdb_tag_n   = r_cdb_tag;
    w_cdb_data_n  = r_cdb_data;
    w_ld_free_n   = '0;
    w_st_free_n   = '0;
    w_pop         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty && w_hd_rdy) begin
          w_state_nxt   = S_MEM_WAIT;
          w_mem_req_n   = 1'b1;
          w_mem_we_n    = !w_hd_ld;
          w_mem_addr_n  = w_sel_addr;
          w_mem_wdata_n = w_sel_data;
        end
      end
      S_MEM_WAIT: begin
        if (bus.mem_ack) begin
          w_mem_req_n = 1'b0;
          if (w_hd_ld) begin
            w_state_nxt  = S_CDB_WAIT;
            w_cdb_req_n  = 1'b1;
            w_cdb_tag_n  = w_head;
            w_cdb_data_n = bus.mem_rdata;
          end else begin
            w_state_nxt = S_IDLE;
            w_st_free_n = {w_hd_idx, !w_hd_idx};
            w_pop       = 1'b1;
          end
        end
      end
      S_CDB_WAIT: begin
        if (bus.cdb_grant) begin
          w_state_nxt = S_IDLE;
          w_cdb_req_n = 1'b0;
          w_ld_free_n = {w_hd_idx, !w_hd_idx};
          w_pop       = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q[r_wr_ptr] <= bus.issue_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_ovf       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cdb_req   <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_ld_free   <= '0;
      r_st_free   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == DEPTH_C);
      r_mem_req   <= w_mem_req_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
      r_cdb_req   <= w_cdb_req_n;
      r_cdb_tag   <= w_cdb_tag_n;
      r_cdb_data  <= w_cdb_data_n;
      r_ld_free   <= w_ld_free_n;
      r_st_free   <= w_st_free_n;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (bus.issue_valid && !w_push) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.mem_req      = r_mem_req;
  assign bus.mem_we       = r_mem_we;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.cdb_req      = r_cdb_req;
  assign bus.cdb_tag      = r_cdb_tag;
  assign bus.cdb_data     = r_cdb_data;
  assign bus.ld_free      = r_ld_free;
  assign bus.st_free      = r_st_free;
  assign bus.q_full       = r_full;
  assign bus.q_count      = r_count;
  assign bus.overflow_err = r_ovf;
endmodule
